// File: rtl/mips_core_pkg.sv
// Shared MIPS core types: branch outcome, LL/SC reservation state and the
// EX/MEM buffer entry layout.
package mips_core_pkg;

    localparam int unsigned EX_BUF_DEPTH = 2;
    localparam int unsigned INSTR_ID_W   = 20;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned LINK_W       = DATA_W - 2;
    localparam int unsigned FAIL_CNT_W   = 16;

    typedef enum logic {
        NOT_TAKEN = 1'b0,
        TAKEN     = 1'b1
    } BranchOutcome;

    typedef enum logic {
        NO_LINK = 1'b0,
        LINKED  = 1'b1
    } LlscState;

    typedef struct packed {
        logic [INSTR_ID_W-1:0] instruction_id;
        logic [DATA_W-1:0]     result;
        BranchOutcome          branch_outcome;
        logic                  is_ll;
        logic                  is_sc;
        logic                  is_sw;
    } ex_mem_entry_t;

endpackage

// File: rtl/llsc_reservation.sv
// LL/SC reservation tracker: link state, word-granular link address and a
// saturating count of failed store-conditionals.
module llsc_reservation
    import mips_core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pop,
    input  logic                  head_valid,
    input  logic                  head_is_ll,
    input  logic                  head_is_sc,
    input  logic                  head_is_sw,
    input  logic [LINK_W-1:0]     head_addr,
    input  logic                  inv_valid,
    input  logic [LINK_W-1:0]     inv_addr,
    output logic                  sc_success,
    output logic [FAIL_CNT_W-1:0] sc_fail_count
);

    LlscState                state_q, state_d;
    logic [LINK_W-1:0]       link_addr_q, link_addr_d;
    logic [FAIL_CNT_W-1:0]   fail_cnt_q, fail_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= NO_LINK;
            link_addr_q <= '0;
            fail_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            link_addr_q <= link_addr_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    // Snoop invalidation is applied before the popped op, so a popped LL wins.
    always_comb begin
        state_d     = state_q;
        link_addr_d = link_addr_q;
        fail_cnt_d  = fail_cnt_q;

        if (inv_valid && (state_q == LINKED) && (inv_addr == link_addr_q)) begin
            state_d = NO_LINK;
        end

        if (pop) begin
            if (head_is_ll) begin
                state_d     = LINKED;
                link_addr_d = head_addr;
            end else if (head_is_sc) begin
                state_d = NO_LINK;
                if (!sc_success && (fail_cnt_q != '1)) begin
                    fail_cnt_d = fail_cnt_q + FAIL_CNT_W'(1);
                end
            end else if (head_is_sw && (head_addr == link_addr_q)) begin
                state_d = NO_LINK;
            end
        end
    end

    always_comb begin
        sc_success    = head_valid && head_is_sc && (state_q == LINKED)
                        && (head_addr == link_addr_q);
        sc_fail_count = fail_cnt_q;
    end

endmodule

// File: rtl/ex_mem_buffer.sv
// EX/MEM pipeline buffer: small FIFO of executed instructions feeding the
// memory stage, with LL/SC reservation tracking on popped entries.
module ex_mem_buffer
    import mips_core_pkg::*;
#(
    parameter int unsigned DEPTH = EX_BUF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INSTR_ID_W-1:0] in_instruction_id,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_result,
    input  BranchOutcome          in_branch_outcome,
    input  logic                  in_is_ll,
    input  logic                  in_is_sc,
    input  logic                  in_is_sw,
    input  logic                  out_ready,
    input  logic                  flush,
    input  logic                  inv_valid,
    input  logic [DATA_W-1:0]     inv_addr,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [INSTR_ID_W-1:0] out_instruction_id,
    output logic [DATA_W-1:0]     out_result,
    output BranchOutcome          out_branch_outcome,
    output logic                  out_is_ll,
    output logic                  out_is_sc,
    output logic                  out_is_sw,
    output logic                  out_sc_success,
    output logic [FAIL_CNT_W-1:0] sc_fail_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    ex_mem_entry_t    entries_q [DEPTH];
    ex_mem_entry_t    entries_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    ex_mem_entry_t    head_c;
    logic             push_c;
    logic             pop_c;
    logic             unused_inv_lsbs;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake and head view depend only on registered state.
    always_comb begin
        out_valid = (count_q != '0);
        in_ready  = (count_q < CNT_W'(DEPTH));
        head_c    = out_valid ? entries_q[rd_ptr_q] : '0;
        push_c    = in_valid && in_ready && !flush;
        pop_c     = out_valid && out_ready && !flush;
    end

    always_comb begin
        entries_d = entries_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                entries_d[wr_ptr_q].instruction_id = in_instruction_id;
                entries_d[wr_ptr_q].result         = in_result;
                entries_d[wr_ptr_q].branch_outcome = in_branch_outcome;
                entries_d[wr_ptr_q].is_ll          = in_is_ll;
                entries_d[wr_ptr_q].is_sc          = in_is_sc;
                entries_d[wr_ptr_q].is_sw          = in_is_sw;
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop_c) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

    always_comb begin
        out_instruction_id = head_c.instruction_id;
        out_result         = head_c.result;
        out_branch_outcome = head_c.branch_outcome;
        out_is_ll          = head_c.is_ll;
        out_is_sc          = head_c.is_sc;
        out_is_sw          = head_c.is_sw;
    end

    // Reservations are word granular; the byte offset of a snoop is ignored.
    assign unused_inv_lsbs = ^inv_addr[1:0];

    llsc_reservation u_llsc (
        .clk           (clk),
        .rst           (rst),
        .pop           (pop_c),
        .head_valid    (out_valid),
        .head_is_ll    (head_c.is_ll),
        .head_is_sc    (head_c.is_sc),
        .head_is_sw    (head_c.is_sw),
        .head_addr     (head_c.result[DATA_W-1:2]),
        .inv_valid     (inv_valid),
        .inv_addr      (inv_addr[DATA_W-1:2]),
        .sc_success    (out_sc_success),
        .sc_fail_count (sc_fail_count)
    );

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Directed vector bench for ex_mem_buffer: FIFO handshake, LL/SC reservation,
// flush and mid-operation reset.
module tb_ex_mem_buffer;
    import mips_core_pkg::*;

    localparam int TG_LL = 4;
    localparam int TG_SC = 2;
    localparam int TG_SW = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [19:0]  in_instruction_id;
    logic         in_valid;
    logic [31:0]  in_result;
    BranchOutcome in_branch_outcome;
    logic         in_is_ll, in_is_sc, in_is_sw;
    logic         out_ready, flush, inv_valid;
    logic [31:0]  inv_addr;
    logic         in_ready, out_valid;
    logic [19:0]  out_instruction_id;
    logic [31:0]  out_result;
    BranchOutcome out_branch_outcome;
    logic         out_is_ll, out_is_sc, out_is_sw, out_sc_success;
    logic [15:0]  sc_fail_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ex_mem_buffer #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .in_instruction_id(in_instruction_id), .in_valid(in_valid),
        .in_result(in_result), .in_branch_outcome(in_branch_outcome),
        .in_is_ll(in_is_ll), .in_is_sc(in_is_sc), .in_is_sw(in_is_sw),
        .out_ready(out_ready), .flush(flush),
        .inv_valid(inv_valid), .inv_addr(inv_addr),
        .in_ready(in_ready), .out_valid(out_valid),
        .out_instruction_id(out_instruction_id), .out_result(out_result),
        .out_branch_outcome(out_branch_outcome),
        .out_is_ll(out_is_ll), .out_is_sc(out_is_sc), .out_is_sw(out_is_sw),
        .out_sc_success(out_sc_success), .sc_fail_count(sc_fail_count)
    );

    typedef struct {
        logic         iv;
        logic [19:0]  id;
        logic [31:0]  res;
        BranchOutcome br;
        logic [2:0]   tags;
        logic         ordy;
        logic         fl;
        logic         invv;
        logic [31:0]  inva;
        logic         e_ir;
        logic         e_ov;
        logic [19:0]  e_id;
        logic [31:0]  e_res;
        BranchOutcome e_br;
        logic [2:0]   e_tags;
        logic         e_sc;
        logic [15:0]  e_fail;
    } vec_t;

    function automatic vec_t mk(int iv, int id, int res, BranchOutcome br, int tags,
                                int ordy, int fl, int invv, int inva,
                                int e_ir, int e_ov, int e_id, int e_res,
                                BranchOutcome e_br, int e_tags, int e_sc, int e_fail);
        vec_t v;
        v.iv = 1'(iv);     v.id = 20'(id);     v.res = 32'(res);  v.br = br;
        v.tags = 3'(tags); v.ordy = 1'(ordy);  v.fl = 1'(fl);
        v.invv = 1'(invv); v.inva = 32'(inva);
        v.e_ir = 1'(e_ir); v.e_ov = 1'(e_ov);  v.e_id = 20'(e_id);
        v.e_res = 32'(e_res); v.e_br = e_br;   v.e_tags = 3'(e_tags);
        v.e_sc = 1'(e_sc); v.e_fail = 16'(e_fail);
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid          = v.iv;
        in_instruction_id = v.id;
        in_result         = v.res;
        in_branch_outcome = v.br;
        {in_is_ll, in_is_sc, in_is_sw} = v.tags;
        out_ready         = v.ordy;
        flush             = v.fl;
        inv_valid         = v.invv;
        inv_addr          = v.inva;
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input int idx, input vec_t v);
        chk({tag, ".in_ready"},  idx, 32'(in_ready),           32'(v.e_ir));
        chk({tag, ".out_valid"}, idx, 32'(out_valid),          32'(v.e_ov));
        chk({tag, ".id"},        idx, 32'(out_instruction_id), 32'(v.e_id));
        chk({tag, ".result"},    idx, out_result,              v.e_res);
        chk({tag, ".branch"},    idx, 32'(out_branch_outcome), 32'(v.e_br));
        chk({tag, ".tags"},      idx, 32'({out_is_ll, out_is_sc, out_is_sw}), 32'(v.e_tags));
        chk({tag, ".sc_ok"},     idx, 32'(out_sc_success),     32'(v.e_sc));
        chk({tag, ".sc_fails"},  idx, 32'(sc_fail_count),      32'(v.e_fail));
    endtask

    task automatic chk_state(input string name, input int idx, input LlscState exp);
        chk(name, idx, 32'(dut.u_llsc.state_q), 32'(exp));
    endtask

    vec_t vecs[$];
    vec_t idle;

    initial begin
        idle = mk(0, 0, 0, NOT_TAKEN, 0, 0, 0, 0, 0, 1, 0, 0, 0, NOT_TAKEN, 0, 0, 0);
        rst = 1'b1;
        drive(idle);

        //        iv id    res     br      tags   rdy fl iv inva    ir ov id   res     br     tags  sc fail
        vecs.push_back(mk(1, 5,  'h10,  TAKEN,     0,     1, 0, 0, 0,     1, 1, 5,  'h10,  TAKEN,     0,     0, 0));
        vecs.push_back(mk(0, 0,  0,     NOT_TAKEN, 0,     1, 0, 0, 0,     1, 0, 0,  0,     NOT_TAKEN, 0,     0, 0));
        vecs.push_back(mk(1, 1,  'h11,  NOT_TAKEN, 0,     0, 0, 0, 0,     1, 1, 1,  'h11,  NOT_TAKEN, 0,     0, 0));
        vecs.push_back(mk(1, 2,  'h22,  TAKEN,     0,     0, 0, 0, 0,     0, 1, 1,  'h11,  NOT_TAKEN, 0,     0, 0));
        vecs.push_back(mk(1, 3,  'h33,  NOT_TAKEN, 0,     0, 0, 0, 0,     0, 1, 1,  'h11,  NOT_TAKEN, 0,     0, 0));
        vecs.push_back(mk(1, 3,  'h33,  NOT_TAKEN, 0,     1, 0, 0, 0,     1, 1, 2,  'h22,  TAKEN,     0,     0, 0));
        vecs.push_back(mk(1, 3,  'h33,  NOT_TAKEN, 0,     1, 0, 0, 0,     1, 1, 3,  'h33,  NOT_TAKEN, 0,     0, 0));
        vecs.push_back(mk(0, 0,  0,     NOT_TAKEN, 0,     1, 0, 0, 0,     1, 0, 0,  0,     NOT_TAKEN, 0,     0, 0));
        vecs.push_back(mk(1, 10, 'h100, NOT_TAKEN, TG_LL, 0, 0, 0, 0,     1, 1, 10, 'h100, NOT_TAKEN, TG_LL, 0, 0));
        vecs.push_back(mk(0, 0,  0,     NOT_TAKEN, 0,     1, 0, 0, 0,     1, 0, 0,  0,     NOT_TAKEN, 0,     0, 0));
        vecs.push_back(mk(1, 11, 'h100, NOT_TAKEN, TG_SC, 0, 0, 0, 0,     1, 1, 11, 'h100, NOT_TAKEN, TG_SC, 1, 0));
        vecs.push_back(mk(0, 0,  0,     NOT_TAKEN, 0,     1, 0, 0, 0,     1, 0, 0,  0,     NOT_TAKEN, 0,     0, 0));
        vecs.push_back(mk(1, 12, 'h100, NOT_TAKEN, TG_LL, 1, 0, 0, 0,     1, 1, 12, 'h100, NOT_TAKEN, TG_LL, 0, 0));
        vecs.push_back(mk(0, 0,  0,     NOT_TAKEN, 0,     1, 0, 0, 0,     1, 0, 0,  0,     NOT_TAKEN, 0,     0, 0));
        vecs.push_back(mk(1, 13, 'h100, NOT_TAKEN, TG_SC, 0, 0, 1, 'h104, 1, 1, 13, 'h100, NOT_TAKEN, TG_SC, 1, 0));
        vecs.push_back(mk(0, 0,  0,     NOT_TAKEN, 0,     0, 0, 1, 'h102, 1, 1, 13, 'h100, NOT_TAKEN, TG_SC, 0, 0));
        vecs.push_back(mk(0, 0,  0,     NOT_TAKEN, 0,     1, 0, 0, 0,     1, 0, 0,  0,     NOT_TAKEN, 0,     0, 1));
        vecs.push_back(mk(1, 20, 'h200, NOT_TAKEN, TG_LL, 1, 0, 0, 0,     1, 1, 20, 'h200, NOT_TAKEN, TG_LL, 0, 1));
        vecs.push_back(mk(1, 21, 'h200, NOT_TAKEN, TG_SW, 1, 0, 0, 0,     1, 1, 21, 'h200, NOT_TAKEN, TG_SW, 0, 1));
        vecs.push_back(mk(1, 22, 'h200, NOT_TAKEN, TG_SC, 1, 0, 0, 0,     1, 1, 22, 'h200, NOT_TAKEN, TG_SC, 0, 1));
        vecs.push_back(mk(0, 0,  0,     NOT_TAKEN, 0,     1, 0, 0, 0,     1, 0, 0,  0,     NOT_TAKEN, 0,     0, 2));
        vecs.push_back(mk(1, 30, 'h300, NOT_TAKEN, TG_LL, 1, 0, 0, 0,     1, 1, 30, 'h300, NOT_TAKEN, TG_LL, 0, 2));
        vecs.push_back(mk(1, 31, 'h300, NOT_TAKEN, TG_LL, 1, 0, 0, 0,     1, 1, 31, 'h300, NOT_TAKEN, TG_LL, 0, 2));
        vecs.push_back(mk(0, 0,  0,     NOT_TAKEN, 0,     1, 0, 1, 'h300, 1, 0, 0,  0,     NOT_TAKEN, 0,     0, 2));
        vecs.push_back(mk(1, 32, 'h300, NOT_TAKEN, TG_SC, 0, 0, 0, 0,     1, 1, 32, 'h300, NOT_TAKEN, TG_SC, 1, 2));
        vecs.push_back(mk(0, 0,  0,     NOT_TAKEN, 0,     1, 0, 0, 0,     1, 0, 0,  0,     NOT_TAKEN, 0,     0, 2));

        // Reset values while rst is held.
        @(negedge clk);
        @(negedge clk);
        check_outs("reset", 0, idle);
        chk_state("reset.state", 0, NO_LINK);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            check_outs("vec", i, vecs[i]);
        end

        // Flush with two entries buffered and a live input keeps the reservation.
        apply(mk(1, 40, 'h400, NOT_TAKEN, TG_LL, 1, 0, 0, 0, 1, 1, 40, 'h400, NOT_TAKEN, TG_LL, 0, 2));
        apply(mk(0, 0, 0, NOT_TAKEN, 0, 1, 0, 0, 0, 1, 0, 0, 0, NOT_TAKEN, 0, 0, 2));
        chk_state("flush.state_pre", 0, LINKED);
        apply(mk(1, 41, 'h41, NOT_TAKEN, 0, 0, 0, 0, 0, 1, 1, 41, 'h41, NOT_TAKEN, 0, 0, 2));
        apply(mk(1, 42, 'h42, NOT_TAKEN, 0, 0, 0, 0, 0, 0, 1, 41, 'h41, NOT_TAKEN, 0, 0, 2));
        check_outs("flush_fill", 0, mk(0, 0, 0, NOT_TAKEN, 0, 0, 0, 0, 0, 0, 1, 41, 'h41, NOT_TAKEN, 0, 0, 2));
        begin
            vec_t fv;
            fv = mk(1, 43, 'h43, NOT_TAKEN, 0, 1, 1, 0, 0, 1, 0, 0, 0, NOT_TAKEN, 0, 0, 2);
            apply(fv);
            check_outs("flush", 0, fv);
            chk_state("flush.state", 0, LINKED);
            fv = mk(1, 44, 'h400, NOT_TAKEN, TG_SC, 0, 0, 0, 0, 1, 1, 44, 'h400, NOT_TAKEN, TG_SC, 1, 2);
            apply(fv);
            check_outs("flush_sc", 0, fv);
            fv = mk(0, 0, 0, NOT_TAKEN, 0, 1, 0, 0, 0, 1, 0, 0, 0, NOT_TAKEN, 0, 0, 2);
            apply(fv);
            check_outs("flush_sc_pop", 0, fv);
            chk_state("flush.state_post", 0, NO_LINK);
        end

        // Asynchronous reset while LINKED with a full buffer.
        apply(mk(1, 50, 'h500, NOT_TAKEN, TG_LL, 1, 0, 0, 0, 1, 1, 50, 'h500, NOT_TAKEN, TG_LL, 0, 2));
        apply(mk(0, 0, 0, NOT_TAKEN, 0, 1, 0, 0, 0, 1, 0, 0, 0, NOT_TAKEN, 0, 0, 2));
        apply(mk(1, 51, 'h51, NOT_TAKEN, 0, 0, 0, 0, 0, 1, 1, 51, 'h51, NOT_TAKEN, 0, 0, 2));
        apply(mk(1, 52, 'h52, NOT_TAKEN, 0, 0, 0, 0, 0, 0, 1, 51, 'h51, NOT_TAKEN, 0, 0, 2));
        chk("rst.pre_in_ready", 0, 32'(in_ready), 32'(0));
        chk_state("rst.pre_state", 0, LINKED);
        @(negedge clk);
        drive(idle);
        rst = 1'b1;
        #1;
        check_outs("rst_mid", 0, idle);
        chk_state("rst_mid.state", 0, NO_LINK);
        @(negedge clk);
        rst = 1'b0;
        begin
            vec_t rv;
            rv = mk(1, 60, 'h60, NOT_TAKEN, 0, 0, 0, 0, 0, 1, 1, 60, 'h60, NOT_TAKEN, 0, 0, 0);
            drive(rv);
            @(posedge clk);
            #1;
            check_outs("rst_push", 0, rv);
            rv = mk(0, 0, 0, NOT_TAKEN, 0, 1, 0, 0, 0, 1, 0, 0, 0, NOT_TAKEN, 0, 0, 0);
            apply(rv);
            check_outs("rst_pop", 0, rv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_buffer.md
EX_MEM_BUFFER -- requirements
Module: ex_mem_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning number of buffer entries (fixed at 2 for this core).
REQ-002 SHALL use one clock and an asynchronous, active-high reset, with ports in this order:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
REQ-003 SHALL have these input ports:
- in_instruction_id  input  20  id of the executed instruction
- in_valid  input  1  ALU result valid
- in_result  input  32  ALU result; the effective address for loads and stores
- in_branch_outcome  input  BranchOutcome  resolved branch outcome
- in_is_ll / in_is_sc / in_is_sw  input  1 each  memory-op tags
- out_ready  input  1  memory stage accepts head
- flush  input  1  discard all buffered entries
- inv_valid  input  1  external store snoop valid
- inv_addr  input  32  external store address
REQ-004 SHALL have these output ports:
- in_ready  output  1  buffer can accept
- out_valid  output  1  head entry valid
- out_instruction_id  output  20  head instruction id
- out_result  output  32  head result
- out_branch_outcome  output  BranchOutcome  head branch outcome
- out_is_ll / out_is_sc / out_is_sw  output  1 each  head memory-op tags
- out_sc_success  output  1  head SC will succeed
- sc_fail_count  output  16  count of failed SCs, saturating

Function
REQ-005 SHALL push an entry on a rising clk edge when in_valid && in_ready && !flush.
REQ-006 SHALL pop the head on a rising clk edge when out_valid && out_ready && !flush.
REQ-007 SHALL drive in_ready = (count < DEPTH) from registered state only, with no combinational path from in_* to any output.
REQ-008 SHALL have 1-cycle latency: an entry pushed at edge N into an empty buffer appears on out_* after edge N.
REQ-009 SHALL keep count unchanged on a simultaneous push and pop, with both pointers advancing.
REQ-010 SHALL advance the read/write pointers modulo DEPTH, wrapping 1 -> 0.
REQ-011 SHALL drive out_* from the head entry while count > 0, and drive all zeros (branch outcome NOT_TAKEN) when empty.
REQ-012 SHALL give flush priority over push and pop: count = 0 and pointers = 0 next cycle, the same-cycle input is dropped, and link state is unchanged.
REQ-013 SHALL hold the reservation FSM in state NO_LINK or LINKED, with link_addr[31:2] registered.
REQ-014 SHALL, on pop of an LL, enter LINKED with link_addr = out_result[31:2].
REQ-015 SHALL, on pop of an SC, enter NO_LINK regardless of outcome.
REQ-016 SHALL, on pop of an SW with out_result[31:2] == link_addr, enter NO_LINK.
REQ-017 SHALL, on inv_valid with inv_addr[31:2] == link_addr while LINKED, enter NO_LINK.
REQ-018 SHALL drive out_sc_success = out_valid && out_is_sc && LINKED && (out_result[31:2] == link_addr), using registered state only.
REQ-019 SHALL apply same-cycle reservation events in this order: invalidate, then popped op; a popped LL therefore leaves LINKED, and a popped SC keeps its presented out_sc_success.
REQ-020 SHALL increment sc_fail_count on each SC pop with out_sc_success = 0, saturating at 16'hFFFF.
REQ-021 SHALL change no state for in_valid = 0 cycles or for blocked pushes.

Reset
REQ-022 SHALL, while rst = 1 (asynchronous), reset as follows:
- count, pointers, link_addr and sc_fail_count = 0
- FSM = NO_LINK
- out_valid = 0, in_ready = 1
- all out_* = 0
REQ-023 SHALL discard buffered entries and the reservation on reset asserted mid-operation, with the first push accepted on the first edge after rst deasserts.

Structure
REQ-024 SHALL place the LlscState enum (NO_LINK, LINKED) and EX_BUF_DEPTH = 2 in mips_core_pkg, reusing the existing BranchOutcome.
REQ-025 SHALL implement reservation tracking (FSM, link_addr, sc_fail_count) in sub-module llsc_reservation, driven by pop and snoop events.

Verification
REQ-026 SHALL cover: push id 5, result 0x10, out_ready = 1 -> out_valid = 1 one cycle later with id 5; pop -> empty.
REQ-027 SHALL cover: out_ready = 0 with 3 valid inputs -> in_ready = 0 after 2 pushes, the third input is held; releasing out_ready pops ids in order.
REQ-028 SHALL cover: LL at 0x100 popped, then SC at 0x100 -> out_sc_success = 1, sc_fail_count = 0.
REQ-029 SHALL cover: LL at 0x100, then inv_addr 0x104 (no effect), then inv_addr 0x102 -> SC at 0x100 gives out_sc_success = 0 and sc_fail_count = 1.
REQ-030 SHALL cover: 2 entries buffered plus flush with in_valid = 1 -> out_valid = 0 next cycle, LINKED state retained.
REQ-031 SHALL cover: rst pulse asserted mid-buffer with LINKED -> outputs zero immediately, FSM = NO_LINK, in_ready = 1.
